// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage with credit-limited in-order imem requests
// and a {pc, instr} FIFO presented to decode over valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [6:0]  if_op_code,
  output logic [2:0]  if_funct3,
  output logic [6:0]  if_funct7
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEP = (CW+1)'(DEPTH);
  logic [31:0] pc_q, pc_d, if_pc_q, if_pc_d, if_instr_q, if_instr_d;
  logic [CW-1:0] inflight_q, inflight_d, drop_q, drop_d, count_q, count_d, left;
  logic [AW-1:0] rq_wr_q, rq_wr_d, rq_rd_q, rq_rd_d, ff_wr_q, ff_wr_d, ff_rd_q, ff_rd_d;
  logic [31:0] rq_mem_q [DEPTH];
  logic [63:0] ff_mem_q [DEPTH];
  logic req_fire, rsp_fire, push, pop;
  always_comb begin
    imem_req_valid = !rst && !redirect_valid && ({1'b0, inflight_q} + {1'b0, count_q} < DEP);
    req_fire = imem_req_valid && imem_req_ready;
    rsp_fire = imem_rsp_valid && inflight_q != '0;
    push = rsp_fire && drop_q == '0 && !redirect_valid;
    pop = if_valid && if_ready && !redirect_valid;
    pc_d = redirect_valid ? {redirect_pc[31:2], 2'b00} : pc_q + (req_fire ? 32'd4 : 32'd0);
    inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_fire);
    // a redirect squashes every request still outstanding after this cycle's response
    drop_d = redirect_valid ? inflight_q - CW'(rsp_fire) : drop_q - CW'(rsp_fire && drop_q != '0);
    left = count_q - CW'(pop);
    count_d = redirect_valid ? '0 : left + CW'(push);
    rq_wr_d = rq_wr_q + AW'(req_fire);
    rq_rd_d = rq_rd_q + AW'(rsp_fire);
    ff_wr_d = ff_wr_q + AW'(push);
    ff_rd_d = redirect_valid ? ff_wr_q : ff_rd_q + AW'(pop);
    // output registers always hold the entry that will be the FIFO head next cycle
    {if_pc_d, if_instr_d} = (push && left == '0) ? {rq_mem_q[rq_rd_q], imem_rsp_data}
                          : (left != '0 && !redirect_valid) ? ff_mem_q[ff_rd_d]
                          : {if_pc_q, if_instr_q};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      inflight_q <= '0;
      drop_q <= '0;
      count_q <= '0;
      rq_wr_q <= '0;
      rq_rd_q <= '0;
      ff_wr_q <= '0;
      ff_rd_q <= '0;
      if_pc_q <= '0;
      if_instr_q <= '0;
    end else begin
      pc_q <= pc_d;
      inflight_q <= inflight_d;
      drop_q <= drop_d;
      count_q <= count_d;
      rq_wr_q <= rq_wr_d;
      rq_rd_q <= rq_rd_d;
      ff_wr_q <= ff_wr_d;
      ff_rd_q <= ff_rd_d;
      if_pc_q <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (req_fire) rq_mem_q[rq_wr_q] <= pc_q;
    if (push) ff_mem_q[ff_wr_q] <= {rq_mem_q[rq_rd_q], imem_rsp_data};
  end
  assign imem_req_addr = {pc_q[31:2], 2'b00};
  assign if_valid = count_q != '0;
  assign if_pc = if_pc_q;
  assign if_instr = if_instr_q;
  assign if_op_code = if_instr_q[6:0];
  assign if_funct3 = if_instr_q[14:12];
  assign if_funct7 = if_instr_q[31:25];
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: queue-based reference model plus field vectors and directed
// corner sequences for the fetch stage.
module tb_fetch_unit;
  localparam int DEPTH = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic imem_req_valid, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
  logic [31:0] imem_req_addr, imem_rsp_data = '0, redirect_pc = '0, if_pc, if_instr;
  logic redirect_valid = 1'b0, if_valid, if_ready = 1'b0;
  logic [6:0] if_op_code, if_funct7;
  logic [2:0] if_funct3;
  fetch_unit #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .if_op_code(if_op_code), .if_funct3(if_funct3), .if_funct7(if_funct7)
  );
  always #5 clk = ~clk;
  typedef struct {logic [31:0] addr; int due;} mreq_t;
  typedef struct {logic [31:0] instr; logic [6:0] op; logic [2:0] f3; logic [6:0] f7;} vec_t;
  int n_chk = 0, n_fail = 0, cyc = 0, lat = 1;
  bit rdy, ifr, force_rsp, ov_en;
  logic [31:0] ov_data, m_pc;
  logic [31:0] m_infl[$], hs[$];
  logic [63:0] m_fifo[$];
  mreq_t mq[$];
  int m_drop;
  vec_t tbl[5];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    imem_rsp_valid = 1'b0; if_ready = 1'b1; imem_req_ready = 1'b1;
    #1 chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; redirect_valid = 1'b0;
    m_pc = 32'h0; m_drop = 0;
    m_infl.delete(); m_fifo.delete(); mq.delete(); hs.delete();
    force_rsp = 1'b0; ov_en = 1'b0;
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
  endtask
  task automatic step(input bit redir = 1'b0, input logic [31:0] rpc = 32'h0);
    logic [31:0] p;
    bit m_reqv, mrsp, rsp;
    redirect_valid = redir; redirect_pc = rpc; imem_req_ready = rdy; if_ready = ifr;
    mrsp = !force_rsp && mq.size() > 0 && mq[0].due <= cyc;
    imem_rsp_valid = force_rsp || mrsp;
    imem_rsp_data = force_rsp ? 32'hDEAD_BEEF : !mrsp ? 32'h0 : ov_en ? ov_data : mq[0].addr ^ 32'hA5A5_0000;
    #1;
    m_reqv = !redir && (m_infl.size() + m_fifo.size() < DEPTH);
    chk("req_valid", 32'(imem_req_valid), 32'(m_reqv));
    if (m_reqv) chk("req_addr", imem_req_addr, m_pc);
    if (if_valid && if_ready && !redir) hs.push_back(if_pc);
    @(posedge clk);
    rsp = imem_rsp_valid && m_infl.size() > 0;
    if (mrsp) void'(mq.pop_front());
    if (m_fifo.size() > 0 && ifr && !redir) void'(m_fifo.pop_front());
    if (rsp) begin
      p = m_infl.pop_front();
      if (m_drop > 0) m_drop--;
      else if (!redir) m_fifo.push_back({p, imem_rsp_data});
    end
    if (redir) begin
      m_fifo.delete();
      m_drop = m_infl.size();
      m_pc = {rpc[31:2], 2'b00};
    end else if (m_reqv && rdy) begin
      m_infl.push_back(m_pc);
      mq.push_back('{m_pc, cyc + lat});
      m_pc += 32'd4;
    end
    cyc++;
    @(negedge clk);
    chk("if_valid", 32'(if_valid), 32'(m_fifo.size() > 0));
    if (m_fifo.size() > 0) begin
      chk("if_pc", if_pc, m_fifo[0][63:32]);
      chk("if_instr", if_instr, m_fifo[0][31:0]);
      chk("if_op_code", 32'(if_op_code), 32'(m_fifo[0][6:0]));
      chk("if_funct3", 32'(if_funct3), 32'(m_fifo[0][14:12]));
      chk("if_funct7", 32'(if_funct7), 32'(m_fifo[0][31:25]));
    end
  endtask
  initial begin
    bit ok;
    logic [31:0] snap_pc, snap_instr;
    tbl[0] = '{32'h00A2_8293, 7'h13, 3'd0, 7'h00};
    tbl[1] = '{32'h40B5_0533, 7'h33, 3'd0, 7'h20};
    tbl[2] = '{32'h0062_A023, 7'h23, 3'd2, 7'h00};
    tbl[3] = '{32'h02C5_D6B3, 7'h33, 3'd5, 7'h01};
    tbl[4] = '{32'hFFFF_FFFF, 7'h7F, 3'd7, 7'h7F};
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      do_reset();
      ov_en = 1'b1; ov_data = tbl[i].instr; lat = 1; rdy = 1'b1; ifr = 1'b0;
      repeat (3) step();
      chk("vec_pc", if_pc, 32'h0);
      chk("vec_instr", if_instr, tbl[i].instr);
      chk("vec_op", 32'(if_op_code), 32'(tbl[i].op));
      chk("vec_f3", 32'(if_funct3), 32'(tbl[i].f3));
      chk("vec_f7", 32'(if_funct7), 32'(tbl[i].f7));
    end
    do_reset();
    rdy = 1'b0; ifr = 1'b1; force_rsp = 1'b1;
    step();
    force_rsp = 1'b0; rdy = 1'b1; lat = 1;
    step();
    chk("stale_if_valid", 32'(if_valid), 32'd0);
    repeat (12) step();
    chk("seq_count", 32'(hs.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++) chk("seq_pc", hs[i], 32'(i * 4));
    ifr = 1'b0;
    step();
    snap_pc = if_pc; snap_instr = if_instr;
    repeat (9) step();
    chk("bp_req_stall", 32'(imem_req_valid), 32'd0);
    chk("bp_pc_stable", if_pc, snap_pc);
    chk("bp_instr_stable", if_instr, snap_instr);
    ifr = 1'b1;
    repeat (10) step();
    ok = 1'b1;
    for (int i = 0; i + 1 < hs.size(); i++) if (hs[i+1] != hs[i] + 32'd4) ok = 1'b0;
    chk("bp_order", 32'(ok), 32'd1);
    do_reset();
    lat = 3; rdy = 1'b1; ifr = 1'b1;
    step(); step();
    step(1'b1, 32'h103);
    chk("rd_addr", imem_req_addr, 32'h100);
    repeat (12) step();
    chk("rd_count", 32'(hs.size() > 0), 32'd1);
    chk("rd_first_pc", hs[0], 32'h100);
    do_reset();
    lat = 2; rdy = 1'b1; ifr = 1'b0;
    repeat (3) step();
    ifr = 1'b1;
    step(1'b1, 32'h200);
    chk("co_if_valid", 32'(if_valid), 32'd0);
    lat = 1;
    repeat (8) step();
    chk("co_first_pc", hs[0], 32'h200);
    do_reset();
    lat = 2; rdy = 1'b1; ifr = 1'b1;
    step(); step();
    step(1'b1, 32'h300);
    repeat (10) step();
    chk("drop1_first_pc", hs[0], 32'h300);
    do_reset();
    lat = 1; rdy = 1'b1; ifr = 1'b1;
    step(1'b1, 32'hFFFF_FFFC);
    repeat (10) step();
    chk("wrap_count", 32'(hs.size() >= 3), 32'd1);
    chk("wrap_pc0", hs[0], 32'hFFFF_FFFC);
    chk("wrap_pc1", hs[1], 32'h0);
    chk("wrap_pc2", hs[2], 32'h4);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rdy = $urandom_range(3) != 0;
      ifr = $urandom_range(2) != 0;
      lat = $urandom_range(4, 1);
      force_rsp = m_infl.size() == 0 && $urandom_range(15) == 0;
      case ($urandom_range(24))
        0: step(1'b1, $urandom);
        1: step(1'b1, 32'hFFFF_FFF0 | ($urandom & 32'hF));
        default: step();
      endcase
      force_rsp = 1'b0;
      if ($urandom_range(600) == 0) do_reset();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
